// File: rtl/receptor_unstriping.sv
// receptor_unstriping: lane-word buffer, byte un-striper and
// packet framer producing control_dk codes for the rx link layer.
module receptor_unstriping #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       rx_valid,
  input  logic [7:0] rx_lane0,
  input  logic [7:0] rx_lane1,
  input  logic [7:0] rx_lane2,
  input  logic [7:0] rx_lane3,
  input  logic [7:0] com,
  input  logic [7:0] skp,
  input  logic [7:0] stp,
  input  logic [7:0] sdp,
  input  logic [7:0] end_ok,
  input  logic [7:0] edb,
  input  logic [7:0] fts,
  input  logic [7:0] idle,
  output logic [7:0] rx_DataS,
  output logic [3:0] rx_control_dk,
  output logic       rx_out_valid,
  output logic       rx_locked,
  output logic       rx_error,
  output logic       rx_overflow
);

  localparam logic [0:0] OUT_PKT = 1'b0;
  localparam logic [0:0] IN_PKT  = 1'b1;

  logic [31:0] fifo_q [FIFO_DEPTH];
  logic [1:0]  wr_q, rd_q;
  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d, nxt;
  logic        busy_q, busy_d;
  logic [0:0]  st_q, st_d;
  logic [7:0]  data_q, byte_d;
  logic [3:0]  ctrl_q, code_d;
  logic        ov_q, lock_q, err_q, ovf_q;
  logic        all_com, wr_req, pop, wr_en, drop;
  logic        empty, full, emit, err_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[0] == rd_q[0]) && (wr_q[1] != rd_q[1]);

  // Lock qualification and FIFO write/pop arbitration
  always_comb begin
    all_com = (rx_lane0 == com) && (rx_lane1 == com) &&
              (rx_lane2 == com) && (rx_lane3 == com);
    wr_req  = rx_valid && (lock_q || all_com);
    pop     = (!busy_q || (cnt_q == 2'd3)) && !empty;
    wr_en   = wr_req && (!full || pop);
    drop    = wr_req && full && !pop;
  end

  // Serializer: pick the byte presented at the next edge
  always_comb begin
    emit   = 1'b0;
    byte_d = 8'h00;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    word_d = word_q;
    nxt    = cnt_q + 2'd1;
    if (pop) begin
      word_d = fifo_q[rd_q[0]];
      byte_d = word_d[7:0];
      cnt_d  = 2'd0;
      busy_d = 1'b1;
      emit   = 1'b1;
    end else if (busy_q && (cnt_q != 2'd3)) begin
      byte_d = word_q[{nxt, 3'b000} +: 8];
      cnt_d  = nxt;
      emit   = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Framer: classify the emitted byte against packet state
  always_comb begin
    code_d = 4'h0;
    err_d  = 1'b0;
    st_d   = st_q;
    if (st_q == OUT_PKT) begin
      if (byte_d == stp) begin
        code_d = 4'h3;
        st_d   = IN_PKT;
      end else if (byte_d == sdp) begin
        code_d = 4'h4;
        st_d   = IN_PKT;
      end else if (byte_d == com) begin
        code_d = 4'h1;
      end else if (byte_d == skp) begin
        code_d = 4'h2;
      end else if (byte_d == fts) begin
        code_d = 4'h7;
      end else if (byte_d == idle) begin
        code_d = 4'h8;
      end else begin
        code_d = 4'hF;
        err_d  = 1'b1;
      end
    end else begin
      if (byte_d == end_ok) begin
        code_d = 4'h5;
        st_d   = OUT_PKT;
      end else if (byte_d == edb) begin
        code_d = 4'h6;
        st_d   = OUT_PKT;
      end else if ((byte_d == stp) || (byte_d == sdp)) begin
        code_d = 4'hF;
        err_d  = 1'b1;
      end else begin
        code_d = 4'h0;
      end
    end
  end

  // FIFO storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (!rst && enb && wr_en) begin
      fifo_q[wr_q[0]] <= {rx_lane3, rx_lane2, rx_lane1, rx_lane0};
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 2'd0;
      rd_q    <= 2'd0;
      word_q  <= 32'h0;
      cnt_q   <= 2'd0;
      busy_q  <= 1'b0;
      st_q    <= OUT_PKT;
      data_q  <= 8'h00;
      ctrl_q  <= 4'h0;
      ov_q    <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (enb) begin
      lock_q <= lock_q | (rx_valid & all_com);
      ovf_q  <= ovf_q | drop;
      if (wr_en) wr_q <= wr_q + 2'd1;
      if (pop) rd_q <= rd_q + 2'd1;
      word_q <= word_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      ov_q   <= emit;
      err_q  <= emit & err_d;
      if (emit) begin
        data_q <= byte_d;
        ctrl_q <= code_d;
        st_q   <= st_d;
      end
    end
  end

  assign rx_DataS      = data_q;
  assign rx_control_dk = ctrl_q;
  assign rx_out_valid  = ov_q;
  assign rx_locked     = lock_q;
  assign rx_error      = err_q;
  assign rx_overflow   = ovf_q;

endmodule
